// File: rtl/range_reducer_if.sv
// Operand/result handshake bundle for range_reducer (valid/ready on both sides).
// master drives operands and takes results; slave is the reducer itself.
interface range_reducer_if #(
  parameter int num_of_int  = 3,
  parameter int num_of_frac = 23,
  parameter int num_of_k    = 4
);
  logic                   IN_VALID;
  logic                   IN_READY;
  logic [num_of_int-1:0]  IN_INT;
  logic [num_of_frac-1:0] IN_FRAC;
  logic                   OUT_VALID;
  logic                   OUT_READY;
  logic [num_of_k-1:0]    OUT_K;
  logic [num_of_int-1:0]  OUT_INT;
  logic [num_of_frac-1:0] OUT_FRAC;

  modport master (
    output IN_VALID, IN_INT, IN_FRAC, OUT_READY,
    input  IN_READY, OUT_VALID, OUT_K, OUT_INT, OUT_FRAC
  );

  modport slave (
    input  IN_VALID, IN_INT, IN_FRAC, OUT_READY,
    output IN_READY, OUT_VALID, OUT_K, OUT_INT, OUT_FRAC
  );
endinterface

// File: rtl/range_reducer.sv
// Reduces unsigned fixed-point x to x = k*LN2 + r (0 <= r < LN2) by repeated subtraction.
// Latency k+1 cycles after accept; one operand in flight, result held until OUT_READY.
module range_reducer #(
  parameter int num_of_int  = 3,
  parameter int num_of_frac = 23,
  parameter int num_of_k    = 4,
  parameter logic [num_of_int+num_of_frac-1:0] LN2 = 26'h058B90C
) (
  input logic         CLK,
  input logic         RST_N,
  range_reducer_if.slave io
);

  localparam int W = num_of_int + num_of_frac;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t              state_q, state_nxt;
  logic [W-1:0]        acc_q, acc_nxt;
  logic [num_of_k-1:0] k_q, k_nxt;
  logic                ge_ln2;
  logic                in_ready_dat;
  logic                out_valid_dat;

  assign ge_ln2 = (acc_q >= LN2);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      acc_q   <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_nxt;
      acc_q   <= acc_nxt;
      k_q     <= k_nxt;
    end
  end

  always_comb begin
    state_nxt     = state_q;
    acc_nxt       = acc_q;
    k_nxt         = k_q;
    in_ready_dat  = 1'b0;
    out_valid_dat = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_dat = 1'b1;
        if (io.IN_VALID) begin
          acc_nxt   = {io.IN_INT, io.IN_FRAC};
          k_nxt     = '0;
          state_nxt = REDUCE;
        end
      end
      REDUCE: begin
        // Subtraction only when guarded by the compare, so acc never wraps.
        if (ge_ln2) begin
          acc_nxt = acc_q - LN2;
          k_nxt   = k_q + 1'b1;
        end else begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid_dat = 1'b1;
        if (io.OUT_READY) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign io.IN_READY  = in_ready_dat;
  assign io.OUT_VALID = out_valid_dat;
  assign io.OUT_K     = k_q;
  assign io.OUT_INT   = acc_q[W-1:num_of_frac];
  assign io.OUT_FRAC  = acc_q[num_of_frac-1:0];

endmodule

// File: doc/range_reducer.md
RANGE_REDUCER -- requirements
Module: range_reducer

Interface
REQ-001 Parameter num_of_int, default 3: weight of the integer field of operand and remainder.
REQ-002 Parameter num_of_frac, default 23: fraction width of operand and remainder.
REQ-003 Parameter num_of_k, default 4: width of the quotient count OUT_K.
REQ-004 Parameter LN2, default 26'h058B90C: ln2 in unsigned Q3.23 (5814540).
REQ-005 CLK  input  1  single clock; all state updates on the rising edge.
REQ-006 RST_N  input  1  reset, asynchronous and active-low.
REQ-007 IN_VALID  input  1  operand offered.
REQ-008 IN_READY  output  1  block can accept an operand.
REQ-009 IN_INT  input  num_of_int  operand integer part, unsigned.
REQ-010 IN_FRAC  input  num_of_frac  operand fraction part.
REQ-011 OUT_VALID  output  1  result available.
REQ-012 OUT_READY  input  1  consumer takes the result.
REQ-013 OUT_K  output  num_of_k  count of LN2 subtractions, so x = OUT_K*LN2 + r.
REQ-014 OUT_INT  output  num_of_int  remainder r integer part.
REQ-015 OUT_FRAC  output  num_of_frac  remainder r fraction part.

Function
REQ-016 The block SHALL treat {IN_INT, IN_FRAC} as one unsigned (num_of_int+num_of_frac)-bit fixed-point word and compute k = floor(x/LN2) and r = x - k*LN2 by repeated subtraction.
REQ-017 The FSM SHALL have the states IDLE, REDUCE and DONE.
REQ-018 IN_READY SHALL be 1 only in IDLE, and OUT_VALID SHALL be 1 only in DONE; both are registered-state decodes.
REQ-019 In IDLE with IN_VALID=1, the block SHALL latch the operand into the accumulator, clear k and go to REDUCE on the same edge.
REQ-020 In REDUCE, each cycle with acc >= LN2 SHALL set acc <= acc - LN2 and k <= k + 1 and stay in REDUCE; the comparison is unsigned and full width.
REQ-021 In REDUCE with acc < LN2, the block SHALL go to DONE and leave acc and k unchanged.
REQ-022 Latency: OUT_VALID SHALL rise exactly k+1 cycles after the accepting edge; the default-parameter maximum is 12 cycles (k=11).
REQ-023 In DONE, OUT_K, OUT_INT and OUT_FRAC SHALL drive k and acc, and SHALL stay stable while OUT_READY=0.
REQ-024 In DONE with OUT_READY=1, the block SHALL return to IDLE; IN_READY is therefore 1 on the following cycle, with no same-cycle pass-through.
REQ-025 IN_VALID SHALL be ignored outside IDLE, and operand changes after acceptance SHALL NOT affect the result.
REQ-026 The subtraction SHALL never underflow, because it is guarded by REQ-020; r SHALL always satisfy 0 <= r < LN2.
REQ-027 For the default parameters, k SHALL NOT exceed 11, so k SHALL NOT wrap in num_of_k=4 bits.
REQ-028 Every output other than the handshake decodes SHALL be a register output.

Reset
REQ-029 While RST_N=0, the block SHALL force state=IDLE, acc=0 and k=0, so OUT_VALID=0, IN_READY=1 and OUT_K/OUT_INT/OUT_FRAC=0.
REQ-030 RST_N assertion in REDUCE or DONE SHALL abort immediately, with no result delivered.
REQ-031 After RST_N deassertion, the first rising edge SHALL be able to accept an operand.

Verification
REQ-032 x=0 (INT=0, FRAC=0) -> OUT_VALID 1 cycle after accept, K=0, INT=0, FRAC=0.
REQ-033 x=1.0 (INT=1, FRAC=0) -> 2 cycles, K=1, INT=0, FRAC=0x2746F4.
REQ-034 x=LN2 exactly, then x=LN2-1 -> K=1, r=0; then K=0, r=0x58B90B (boundary of REQ-020).
REQ-035 x max (INT=7, FRAC=0x7FFFFF) -> 12 cycles, K=11, INT=0, FRAC=0x300C7B.
REQ-036 OUT_READY held 0 for 5 cycles in DONE while IN_VALID toggles and IN_* change -> outputs stable, IN_READY=0; then OUT_READY=1 -> IDLE next cycle and the next operand is accepted.
REQ-037 RST_N pulsed low mid-REDUCE on x max -> all outputs 0 and IN_READY=1 asynchronously; a new operand 1.0 afterwards -> K=1, FRAC=0x2746F4.
